// File: rtl/kvs_multi_checker_if.sv
// Snoop bundle for the kvs insert and lookup/modify/delete ports.
// Latency: none; the bundle holds only wires.
// Backpressure: none; kvs drives everything, the checker only observes.
interface kvs_multi_checker_if #(
   parameter int NUM_KEY_BITS = 8,
   parameter int NUM_VAL_BITS = 8
);
   logic                    busy;
   logic                    insert;
   logic [NUM_KEY_BITS-1:0] ins_key;
   logic [NUM_VAL_BITS-1:0] ins_value;
   logic                    lookup;
   logic [NUM_KEY_BITS-1:0] key;
   logic                    modify;
   logic                    del;
   logic [NUM_VAL_BITS-1:0] mod_value;
   logic                    valid;
   logic [NUM_VAL_BITS-1:0] res;

   modport master (
      output busy, insert, ins_key, ins_value, lookup, key,
             modify, del, mod_value, valid, res
   );

   modport slave (
      input  busy, insert, ins_key, ins_value, lookup, key,
             modify, del, mod_value, valid, res
   );
endinterface

// File: rtl/kvs_multi_checker.sv
// Shadow-model checker tracking NUM_TRACK keys of a kvs hashtable.
// Latency: error pulses register one cycle after the kvs result cycle (NUM_PIPES+1 after lookup).
// Backpressure: none; passive snooper, busy only qualifies inserts.
module kvs_multi_checker #(
   parameter  int NUM_KEY_BITS = 8,
   parameter  int NUM_VAL_BITS = 8,
   parameter  int NUM_PIPES    = 2,
   parameter  int NUM_TRACK    = 4,
   parameter  int CNT_BITS     = 16,
   localparam int OCC_BITS     = $clog2(NUM_TRACK + 1)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_TRACK*NUM_KEY_BITS-1:0] track_keys,
   kvs_multi_checker_if.slave                snoop,
   output logic                              err_pres,
   output logic                              err_val,
   output logic                              err_proto,
   output logic                              err_sticky,
   output logic [CNT_BITS-1:0]               check_cnt,
   output logic [CNT_BITS-1:0]               err_cnt,
   output logic [OCC_BITS-1:0]               occupancy
);

   typedef logic [NUM_PIPES:0][NUM_VAL_BITS-1:0] sval_t;

   // Stage NUM_PIPES is the live shadow; lower stages are what a lookup in flight will see.
   logic [NUM_PIPES:0]   r_sv   [NUM_TRACK];
   sval_t                r_sval [NUM_TRACK];
   logic [NUM_PIPES-1:0] r_lk   [NUM_TRACK];
   logic [NUM_PIPES-1:0] r_al;

   logic [NUM_PIPES:0]   w_sv_nxt   [NUM_TRACK];
   sval_t                w_sval_nxt [NUM_TRACK];
   logic [NUM_PIPES-1:0] w_lk_nxt   [NUM_TRACK];
   logic [NUM_PIPES-1:0] w_al_nxt;
   logic [NUM_TRACK-1:0] w_ins_hit;
   logic [NUM_TRACK-1:0] w_lk_hit;
   logic                 w_ins_acc;
   logic                 w_dup;
   logic                 w_orphan;
   logic                 w_chk;
   logic                 w_pres;
   logic                 w_val;
   logic                 w_any;
   logic [OCC_BITS-1:0]  w_occ_nxt;

   // Key match: scanning downward leaves only the lowest matching slot, so duplicates stay inert.
   always_comb begin
      w_ins_hit = '0;
      w_lk_hit  = '0;
      for (int i = NUM_TRACK - 1; i >= 0; i--) begin
         if (snoop.ins_key == track_keys[i*NUM_KEY_BITS +: NUM_KEY_BITS]) begin
            w_ins_hit    = '0;
            w_ins_hit[i] = 1'b1;
         end
         if (snoop.key == track_keys[i*NUM_KEY_BITS +: NUM_KEY_BITS]) begin
            w_lk_hit    = '0;
            w_lk_hit[i] = 1'b1;
         end
      end
   end

   // Shadow next state: shift, then insert load, then a qualified modify overrides everything.
   always_comb begin
      w_ins_acc = snoop.insert && !snoop.busy;
      w_dup     = 1'b0;
      w_chk     = 1'b0;
      w_pres    = 1'b0;
      w_val     = 1'b0;
      w_occ_nxt = '0;
      for (int i = 0; i < NUM_TRACK; i++) begin
         w_sv_nxt[i]   = r_sv[i];
         w_sval_nxt[i] = r_sval[i];
         w_lk_nxt[i]   = '0;
         for (int j = 0; j < NUM_PIPES; j++) begin
            w_sv_nxt[i][j]   = r_sv[i][j+1];
            w_sval_nxt[i][j] = r_sval[i][j+1];
         end
         for (int j = 0; j < NUM_PIPES - 1; j++) begin
            w_lk_nxt[i][j] = r_lk[i][j+1];
         end
         w_lk_nxt[i][NUM_PIPES-1] = snoop.lookup && w_lk_hit[i];
         if (w_ins_acc && w_ins_hit[i]) begin
            w_dup                    = w_dup | r_sv[i][NUM_PIPES];
            w_sv_nxt[i][NUM_PIPES]   = 1'b1;
            w_sval_nxt[i][NUM_PIPES] = snoop.ins_value;
         end
         if (r_lk[i][0]) begin
            w_chk  = 1'b1;
            w_pres = w_pres | (snoop.valid != r_sv[i][0]);
            w_val  = w_val | (r_sv[i][0] && (snoop.res != r_sval[i][0]));
            if (snoop.modify && r_sv[i][0]) begin
               w_sv_nxt[i]   = {(NUM_PIPES+1){!snoop.del}};
               w_sval_nxt[i] = {(NUM_PIPES+1){snoop.mod_value}};
            end
         end
         w_occ_nxt = w_occ_nxt + OCC_BITS'(w_sv_nxt[i][NUM_PIPES]);
      end
      // Any-lookup tag pipeline: a modify is legal only if some lookup landed NUM_PIPES cycles ago.
      w_al_nxt = '0;
      for (int j = 0; j < NUM_PIPES - 1; j++) begin
         w_al_nxt[j] = r_al[j+1];
      end
      w_al_nxt[NUM_PIPES-1] = snoop.lookup;
      w_orphan = snoop.modify && !r_al[0];
      w_any    = w_pres | w_val | w_dup | w_orphan;
   end

   // Shadow and tag registers; reset discards any check in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TRACK; i++) begin
            r_sv[i]   <= '0;
            r_sval[i] <= '0;
            r_lk[i]   <= '0;
         end
         r_al <= '0;
      end else begin
         for (int i = 0; i < NUM_TRACK; i++) begin
            r_sv[i]   <= w_sv_nxt[i];
            r_sval[i] <= w_sval_nxt[i];
            r_lk[i]   <= w_lk_nxt[i];
         end
         r_al <= w_al_nxt;
      end
   end

   // Error pulses, sticky flag, saturating counters and occupancy of the live shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pres   <= 1'b0;
         err_val    <= 1'b0;
         err_proto  <= 1'b0;
         err_sticky <= 1'b0;
         check_cnt  <= '0;
         err_cnt    <= '0;
         occupancy  <= '0;
      end else begin
         err_pres   <= w_pres;
         err_val    <= w_val;
         err_proto  <= w_dup | w_orphan;
         err_sticky <= err_sticky | w_any;
         if (w_chk && (check_cnt != '1)) begin
            check_cnt <= check_cnt + CNT_BITS'(1);
         end
         if (w_any && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_BITS'(1);
         end
         occupancy <= w_occ_nxt;
      end
   end

endmodule

// File: doc/kvs_multi_checker.md
Name: kvs_multi_checker

Overview:
- Synthesizable, parametrised shadow-model checker for the kvs hashtable. Generalises the single-key (anyconst) harness to NUM_TRACK simultaneously tracked keys.
- Sits beside kvs in sim or hardware and snoops the kvs insert and lookup/modify/delete interfaces.
- Flags presence, value and protocol errors as sticky and pulsed outputs, and keeps saturating check and error counters.

Parameters:
- NUM_KEY_BITS, 8, key width
- NUM_VAL_BITS, 8, value width
- NUM_PIPES, 2, kvs lookup latency in cycles (>=1)
- NUM_TRACK, 4, number of tracked keys (>=1)
- CNT_BITS, 16, width of the check and error counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- track_keys  in  NUM_TRACK*NUM_KEY_BITS  tracked keys, slot i = bits [i*K+:K]; static while rst_n is high
- busy  in  1  kvs busy (snooped)
- insert  in  1  insert request
- ins_key  in  NUM_KEY_BITS  insert key
- ins_value  in  NUM_VAL_BITS  insert value
- lookup  in  1  lookup request
- key  in  NUM_KEY_BITS  lookup key
- modify  in  1  modify/delete strobe
- del  in  1  delete qualifier for modify
- mod_value  in  NUM_VAL_BITS  modify value
- valid  in  1  kvs lookup hit
- res  in  NUM_VAL_BITS  kvs lookup value
- err_pres  out  1  pulse: presence mismatch this cycle
- err_val  out  1  pulse: value mismatch this cycle
- err_proto  out  1  pulse: duplicate insert, or modify with no lookup NUM_PIPES cycles earlier
- err_sticky  out  1  OR of all error pulses since reset
- check_cnt  out  CNT_BITS  completed lookup checks, saturating
- err_cnt  out  CNT_BITS  cycles with any error pulse, saturating
- occupancy  out  clog2(NUM_TRACK+1)  tracked keys currently present (stage NUM_PIPES)

Behaviour:
- Reset values: all shadow valids, lookup tags, pulses, err_sticky and counters = 0. Async assert, sync deassert; in-flight checks are discarded.
- Per slot i: shadow arrays sv[0..NUM_PIPES], sval[0..NUM_PIPES], and tag pipeline lk[0..NUM_PIPES-1].
- Stage NUM_PIPES is the current state; each cycle stage j <= stage j+1.
- Key matching: a key matches the lowest-index slot whose track_key equals it. Duplicate track_keys entries at higher indices are inert.
- Accepted insert: insert && !busy. Insert is ignored when busy=1.
- Accepted insert of a matching key: sv[NUM_PIPES]<=1, sval[NUM_PIPES]<=ins_value. If sv[NUM_PIPES] was already 1: err_proto pulse, and the shadow is overwritten.
- lk[NUM_PIPES-1] <= lookup && key matches slot; lk shifts toward index 0.
- Same-cycle lookup and insert of the same key: the lookup sees the pre-insert state (miss).
- Modify with lk[0]=1 and sv[0]=1: every stage 0..NUM_PIPES <= {!del, mod_value}. This overrides any same-cycle insert load and the shift.
- Modify with lk[0]=1 and sv[0]=0: no state change.
- Modify with lk[0]=0 in every slot and no untracked lookup NUM_PIPES earlier: err_proto. This needs a 1-bit any-lookup pipeline of depth NUM_PIPES.
- Check, combinational on lk[0] of the active slot, registered into the pulses one cycle later:
  - err_pres if valid != sv[0];
  - err_val if sv[0] && res != sval[0].
- check_cnt increments once per cycle in which any slot has lk[0]=1.
- Counters saturate at all-ones. err_cnt increments once per cycle in which any pulse is asserted.
- occupancy = popcount of sv[NUM_PIPES] over all slots, registered.
- Output latency: pulses appear 1 cycle after the kvs result cycle, i.e. NUM_PIPES+1 cycles after the lookup request.

Test Plan:
- Reset, then insert key 0x12 val 0x34 (slot0), then lookup 0x12; drive valid=1 res=0x34 at +2 -> no pulse, check_cnt=1, occupancy=1.
- Same sequence but res=0x35 at +2 -> err_val pulse at +3, err_sticky=1, err_cnt=1.
- Lookup 0x12 at t, modify at t+2 with mod_value 0x55; lookup at t+1, kvs returns 0x55 at t+3 -> no error; del=1 variant expects valid=0 at t+3.
- Insert 0x12 twice with busy=0 -> err_proto on the second insert; insert with busy=1 -> ignored, occupancy unchanged.
- Modify with no lookup two cycles earlier -> err_proto. Assert rst_n=0 with a check in flight -> no pulse, all outputs 0.
- Force err_cnt to all-ones (CNT_BITS=2, 4 errors) -> err_cnt holds at 3.
